pht_sweep: RTL and testbench
============================

Name: pht_sweep

Overview:
- Parametrised successor to the core's 2-bit pattern history table, which sits in the PC stage.
- Adds configurable counter width and index width.
- Adds READ_PORTS independent prediction lookups for multi-issue fetch.
- Replaces single-cycle mass reset with a one-entry-per-cycle init sweep FSM, plus a software `clear` that restarts the sweep.
- Adds same-cycle update-to-read bypass.
- Update comes from ID (resolved branch); lookups are driven by the PC-stage GHR/gshare index.

Parameters:
- INDEX_WIDTH, 10, table index bits; depth = 2**INDEX_WIDTH entries.
- CTR_WIDTH, 2, saturating counter width (>=1).
- READ_PORTS, 2, number of independent lookup ports (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- clear  in  1  restart init sweep (flush all counters to weakly-taken).
- upd_en  in  1  resolved-branch update valid.
- upd_taken  in  1  resolved direction; 1 = taken.
- upd_index  in  INDEX_WIDTH  entry to update.
- rd_index  in  READ_PORTS*INDEX_WIDTH  lookup indices; port p at bits [p*INDEX_WIDTH +: INDEX_WIDTH].
- taken_out  out  READ_PORTS  prediction per port.
- ctr_out  out  READ_PORTS*CTR_WIDTH  counter value per port; port p at [p*CTR_WIDTH +: CTR_WIDTH].
- ready  out  1  table initialised; predictions valid.

Behaviour:
- INIT value = 1 << (CTR_WIDTH-1), i.e. weakly taken; value 2 for CTR_WIDTH=2.
- Prediction = MSB of counter.
- FSM states: SWEEP, READY. Registers: state, sweep_idx[INDEX_WIDTH-1:0].
- Reset:
  - Any edge with rst=0 sets state=SWEEP, sweep_idx=0, ready=0.
  - No table write occurs at that edge.
  - rst has priority over every other input.
- Clear: any edge with rst=1, clear=1 (in either state) behaves identically to reset: state=SWEEP, sweep_idx=0, ready=0, no table write. Any update at that edge is dropped.
- SWEEP state:
  - Each edge with rst=1, clear=0 writes INIT to entry sweep_idx, then increments sweep_idx.
  - The edge that writes entry 2**INDEX_WIDTH-1 also sets state=READY and ready=1; sweep_idx wraps to 0.
  - ready therefore rises exactly 2**INDEX_WIDTH edges after the last reset/clear edge.
- Updates while not READY are ignored, with no queuing.
- Outputs while not ready: taken_out=0 and ctr_out=0 on all ports, masked combinationally from state.
- Update (READY, upd_en=1, clear=0): entry upd_index is written at the edge.
  - taken: counter+1, saturating at all-ones (2**CTR_WIDTH-1).
  - not taken: counter-1, saturating at 0.
  - Arithmetic is CTR_WIDTH-bit; no wrap permitted.
- Reads are combinational from the table.
- Bypass, per port independently: if upd_en=1, ready=1, clear=0 and rd_index[p]==upd_index in the same cycle, ctr_out[p]/taken_out[p] show the post-update (next) value rather than the stored value.
- Ports with differing indices are unaffected by the bypass.
- Multiple read ports may share an index; all see identical values.
- One update per cycle; there is no write conflict, since the sweep and updates are mutually exclusive by state.
- Entries hold their value indefinitely when not updated.

Test Plan:
1. Sweep timing, INDEX_WIDTH=4, CTR_WIDTH=2: hold rst=0 for 3 edges, then release → ready=0 for edges 1..15 and 1 after edge 16; all 16 entries read ctr_out=2, taken_out=1. Hold upd_en=1 during the sweep → no entry changes.
2. Saturation, idx 5: taken×3 → ctr 3,3,3; then not-taken×4 → 2,1,0,0. taken_out after each update: 1,1,1,1,0,0,0. Neighbouring idx 4/6 remain 2.
3. Bypass, READ_PORTS=2, entry 7 currently 2: upd_en=1, upd_taken=1, upd_index=7, rd_index port0=7, port1=3 in the same cycle → port0 ctr_out=3 combinationally; port1 ctr_out=2; entry 7 stored=3 after the edge. Repeat not-taken on entry 0 (currently 0) → port shows 0.
4. Clear: with ready=1, drive entries to mixed values, pulse clear for 1 edge with a concurrent upd_en → ready=0 next cycle, update dropped, ready=1 after 16 more edges, all entries=2. Pulse clear again at sweep_idx=9 → sweep restarts and ready rises 16 edges after the second clear.
5. CTR_WIDTH=3: after init all ctr=4, taken=1. Not-taken×1 on idx 2 → 3, taken=0. Taken×5 → 4,5,6,7,7.
6. Reset mid-operation: assert rst=0 at sweep_idx=10, then at a random time in READY with upd_en=1 → outputs are 0 while not ready, no update is applied, and a full 16-edge sweep completes before ready=1.

Source files
------------

// File: rtl/pht_sweep_if.sv
// Lookup/update bundle between the PC/ID stages and the pattern history table.
// Latency: carries a combinational read path and an edge-registered update path.
// Backpressure: none; the ready flag tells consumers when the predictions are meaningful.
interface pht_sweep_if #(
  parameter int INDEX_WIDTH = 10,
  parameter int CTR_WIDTH   = 2,
  parameter int READ_PORTS  = 2
);
  logic                              clear;
  logic                              upd_en;
  logic                              upd_taken;
  logic [INDEX_WIDTH-1:0]            upd_index;
  logic [READ_PORTS*INDEX_WIDTH-1:0] rd_index;
  logic [READ_PORTS-1:0]             taken_out;
  logic [READ_PORTS*CTR_WIDTH-1:0]   ctr_out;
  logic                              ready;

  modport master (
    output clear, upd_en, upd_taken, upd_index, rd_index,
    input  taken_out, ctr_out, ready
  );

  modport slave (
    input  clear, upd_en, upd_taken, upd_index, rd_index,
    output taken_out, ctr_out, ready
  );
endinterface

// File: rtl/pht_sweep.sv
// Pattern history table of saturating counters, with multi-port lookup and a swept initialisation.
// Latency: lookups are combinational, with a same-cycle bypass of the pending update; updates land at the clock edge.
// Backpressure: none; while the init sweep runs, updates are dropped and the outputs read as zero.
module pht_sweep #(
  parameter int INDEX_WIDTH = 10,
  parameter int CTR_WIDTH   = 2,
  parameter int READ_PORTS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  pht_sweep_if.slave  bus
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  // Counter constants are built from an all-ones pattern, so they stay correct down to CTR_WIDTH=1.
  localparam logic [CTR_WIDTH-1:0]   CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0]   CTR_ONE  = CTR_MAX ^ (CTR_MAX << 1);
  localparam logic [CTR_WIDTH-1:0]   CTR_INIT = CTR_MAX ^ (CTR_MAX >> 1);
  localparam logic [INDEX_WIDTH-1:0] IDX_LAST = '1;
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = IDX_LAST ^ (IDX_LAST << 1);

  typedef enum logic {SWEEP, READY} state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] sweep_idx;
  logic                   ready_q;
  logic [CTR_WIDTH-1:0]   table_q [DEPTH];

  logic [CTR_WIDTH-1:0]   upd_cur;
  logic [CTR_WIDTH-1:0]   upd_nxt;
  logic                   upd_fire;

  assign upd_cur  = table_q[bus.upd_index];
  // An update is live only once the table is initialised and no clear is pending; the bypass uses the same qualifier.
  assign upd_fire = bus.upd_en & ready_q & ~bus.clear;

  // Saturating next value for the entry being updated.
  always_comb begin
    upd_nxt = upd_cur;
    if (bus.upd_taken) begin
      if (upd_cur != CTR_MAX) upd_nxt = upd_cur + CTR_ONE;
    end else begin
      if (upd_cur != '0) upd_nxt = upd_cur - CTR_ONE;
    end
  end

  // Init-sweep FSM plus table writes; the sweep and the updates never write in the same state.
  always_ff @(posedge clk) begin
    if (!rst || bus.clear) begin
      state     <= SWEEP;
      sweep_idx <= '0;
      ready_q   <= 1'b0;
    end else if (state == SWEEP) begin
      table_q[sweep_idx] <= CTR_INIT;
      sweep_idx          <= sweep_idx + IDX_ONE;
      if (sweep_idx == IDX_LAST) begin
        state   <= READY;
        ready_q <= 1'b1;
      end
    end else begin
      if (bus.upd_en) table_q[bus.upd_index] <= upd_nxt;
    end
  end

  // Each lookup port checks independently for a same-cycle update to its entry, then is masked to zero until ready.
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [INDEX_WIDTH-1:0] rd_idx;
    logic [CTR_WIDTH-1:0]   rd_val;

    assign rd_idx = bus.rd_index[p*INDEX_WIDTH +: INDEX_WIDTH];
    assign rd_val = (state != READY)                         ? '0      :
                    (upd_fire && rd_idx == bus.upd_index)   ? upd_nxt :
                                                              table_q[rd_idx];
    assign bus.ctr_out[p*CTR_WIDTH +: CTR_WIDTH] = rd_val;
    assign bus.taken_out[p]                      = rd_val[CTR_WIDTH-1];
  end

  assign bus.ready = ready_q;

endmodule

// File: tb/tb_pht_sweep.sv
// Self-checking bench for pht_sweep: 2-bit and 3-bit counter tables driven in lockstep against a table model.
// Latency: every cycle, the outputs are compared at the negedge, after the inputs have settled and before the next edge.
// Backpressure: not applicable; the stimulus mixes directed steps with random update, clear and reset traffic.
module tb_pht_sweep;
  localparam int IW    = 4;
  localparam int RP    = 2;
  localparam int DEPTH = 1 << IW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pht_sweep_if #(.INDEX_WIDTH(IW), .CTR_WIDTH(2), .READ_PORTS(RP)) bus2 ();
  pht_sweep_if #(.INDEX_WIDTH(IW), .CTR_WIDTH(3), .READ_PORTS(RP)) bus3 ();

  pht_sweep #(.INDEX_WIDTH(IW), .CTR_WIDTH(2), .READ_PORTS(RP)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  pht_sweep #(.INDEX_WIDTH(IW), .CTR_WIDTH(3), .READ_PORTS(RP)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int vectors    = 0;
  int miscompares = 0;

  // Model state: the counter values of each table, and the count of sweep edges since the last reset/clear.
  int mtab [2][DEPTH];
  int mcnt;

  // Last observed outputs, per instance (0 = 2-bit, 1 = 3-bit).
  logic [31:0] g_ctr [2];
  logic [31:0] g_tk  [2];
  logic [31:0] g_rdy [2];

  function automatic int cw(int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int cmax(int i);
    return (1 << cw(i)) - 1;
  endfunction

  function automatic int cinit(int i);
    return 1 << (cw(i) - 1);
  endfunction

  function automatic int sat(int i, int v, bit t);
    if (t) return (v == cmax(i)) ? v : v + 1;
    return (v == 0) ? 0 : v - 1;
  endfunction

  // Value a lookup should present this cycle, given the current model state and the live update.
  function automatic int model_read(int i, int idx, bit c, bit ue, bit ut, int ui);
    if (mcnt < DEPTH) return 0;
    if (ue && !c && idx == ui) return sat(i, mtab[i][idx], ut);
    return mtab[i][idx];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int port_val(int i, int p);
    return int'((g_ctr[i] >> (p * cw(i)))) & cmax(i);
  endfunction

  // One clock cycle: drive the inputs, check the outputs against the model, then take the edge and advance the model.
  task automatic step(input bit rn, input bit c, input bit ue, input bit ut,
                      input int ui, input int r0, input int r1, input string tag);
    logic [31:0] e_ctr, e_tk;
    int idx, v;
    @(negedge clk);
    rst            = rn;
    bus2.clear     = c;  bus3.clear     = c;
    bus2.upd_en    = ue; bus3.upd_en    = ue;
    bus2.upd_taken = ut; bus3.upd_taken = ut;
    bus2.upd_index = 4'(ui); bus3.upd_index = 4'(ui);
    bus2.rd_index  = {4'(r1), 4'(r0)};
    bus3.rd_index  = {4'(r1), 4'(r0)};
    #1;
    g_ctr[0] = 32'(bus2.ctr_out);   g_ctr[1] = 32'(bus3.ctr_out);
    g_tk[0]  = 32'(bus2.taken_out); g_tk[1]  = 32'(bus3.taken_out);
    g_rdy[0] = 32'(bus2.ready);     g_rdy[1] = 32'(bus3.ready);
    for (int i = 0; i < 2; i++) begin
      e_ctr = '0;
      e_tk  = '0;
      for (int p = 0; p < RP; p++) begin
        idx = (p == 0) ? r0 : r1;
        v   = model_read(i, idx, c, ue, ut, ui);
        e_ctr = e_ctr | (32'(v) << (p * cw(i)));
        e_tk[p] = v[cw(i)-1];
      end
      chk($sformatf("%s/w%0d/ready", tag, cw(i)), g_rdy[i], (mcnt >= DEPTH) ? 32'd1 : 32'd0);
      chk($sformatf("%s/w%0d/ctr", tag, cw(i)), g_ctr[i], e_ctr);
      chk($sformatf("%s/w%0d/taken", tag, cw(i)), g_tk[i], e_tk);
    end
    @(posedge clk);
    if (!rn || c) begin
      mcnt = 0;
    end else if (mcnt < DEPTH) begin
      mcnt++;
      if (mcnt == DEPTH)
        for (int i = 0; i < 2; i++)
          for (int k = 0; k < DEPTH; k++) mtab[i][k] = cinit(i);
    end else if (ue) begin
      for (int i = 0; i < 2; i++) mtab[i][ui] = sat(i, mtab[i][ui], ut);
    end
  endtask

  task automatic read_all(input string tag);
    for (int k = 0; k < DEPTH / 2; k++) step(1, 0, 0, 0, 0, 2 * k, 2 * k + 1, tag);
  endtask

  task automatic rnd_step(input string tag, input int clr_rate, input int rst_rate);
    bit rn, c;
    int ui, r0, r1;
    rn = !(rst_rate > 0 && $urandom_range(1, rst_rate) == 1);
    c  = (clr_rate > 0 && $urandom_range(1, clr_rate) == 1);
    ui = int'($urandom_range(0, DEPTH - 1));
    r0 = $urandom_range(0, 1) ? ui : int'($urandom_range(0, DEPTH - 1));
    r1 = $urandom_range(0, 1) ? ui : int'($urandom_range(0, DEPTH - 1));
    step(rn, c, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ui, r0, r1, tag);
  endtask

  initial begin
    int exp_a [7];
    int exp_t [7];
    bit dir_a [7];
    int exp_b [5];

    rst = 1'b0;
    mcnt = 0;
    bus2.clear = 0; bus2.upd_en = 0; bus2.upd_taken = 0; bus2.upd_index = '0; bus2.rd_index = '0;
    bus3.clear = 0; bus3.upd_en = 0; bus3.upd_taken = 0; bus3.upd_index = '0; bus3.rd_index = '0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < DEPTH; k++) mtab[i][k] = 0;
    repeat (2) @(posedge clk);

    // Sweep timing, with updates held active throughout the reset and the sweep.
    for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 3, 3, 0, "t1_rst");
    for (int k = 0; k < DEPTH; k++) step(1, 0, 1, k[0], k, k, 15 - k, "t1_sweep");
    read_all("t1_read");
    chk("t1_const_ctr", 32'(port_val(0, 1)), 32'd2);
    chk("t1_const_taken", g_tk[0], 32'd3);

    // Saturation on entry 5 (port 0 sees the bypassed value; port 1 watches the neighbours).
    dir_a = '{1, 1, 1, 0, 0, 0, 0};
    exp_a = '{3, 3, 3, 2, 1, 0, 0};
    exp_t = '{1, 1, 1, 1, 0, 0, 0};
    for (int k = 0; k < 7; k++) begin
      step(1, 0, 1, dir_a[k], 5, 5, (k % 2 == 0) ? 4 : 6, "t2_sat");
      chk("t2_ctr_w2", 32'(port_val(0, 0)), 32'(exp_a[k]));
      chk("t2_taken_w2", 32'(g_tk[0][0]), 32'(exp_t[k]));
      chk("t2_neigh_w2", 32'(port_val(0, 1)), 32'd2);
    end

    // Bypass on port 0 only, then the stored value after the edge, then not-taken floor on entry 0.
    step(1, 0, 1, 1, 7, 7, 3, "t3_byp");
    chk("t3_byp_p0", 32'(port_val(0, 0)), 32'd3);
    chk("t3_byp_p1", 32'(port_val(0, 1)), 32'd2);
    step(1, 0, 0, 0, 0, 7, 7, "t3_stored");
    chk("t3_stored", 32'(port_val(0, 1)), 32'd3);
    step(1, 0, 1, 0, 0, 1, 2, "t3_dn");
    step(1, 0, 1, 0, 0, 1, 2, "t3_dn");
    step(1, 0, 1, 0, 0, 0, 0, "t3_floor");
    chk("t3_floor_p0", 32'(port_val(0, 0)), 32'd0);
    chk("t3_floor_p1", 32'(port_val(0, 1)), 32'd0);

    // 3-bit counters: one not-taken on entry 2, then five taken.
    step(1, 0, 1, 0, 2, 2, 9, "t5_dn");
    chk("t5_dn_w3", 32'(port_val(1, 0)), 32'd3);
    chk("t5_dn_taken_w3", 32'(g_tk[1][0]), 32'd0);
    chk("t5_other_w3", 32'(port_val(1, 1)), 32'd4);
    exp_b = '{4, 5, 6, 7, 7};
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 1, 1, 2, 9, 2, "t5_up");
      chk("t5_up_w3", 32'(port_val(1, 1)), 32'(exp_b[k]));
    end

    // Clear with a concurrent update, then a clear in the middle of a sweep.
    for (int k = 0; k < 40; k++) rnd_step("t4_mix", 0, 0);
    step(1, 1, 1, 1, 5, 5, 6, "t4_clear");
    for (int k = 0; k < DEPTH; k++) rnd_step("t4_sweep", 0, 0);
    read_all("t4_read");
    for (int k = 0; k < 20; k++) rnd_step("t4_mix2", 0, 0);
    step(1, 1, 0, 0, 0, 1, 2, "t4_clear1");
    for (int k = 0; k < 9; k++) rnd_step("t4_part", 0, 0);
    step(1, 1, 1, 0, 3, 3, 4, "t4_clear2");
    for (int k = 0; k < DEPTH; k++) rnd_step("t4_sweep2", 0, 0);
    read_all("t4_read2");

    // Reset partway through a sweep, and again while ready with an update pending.
    step(1, 1, 0, 0, 0, 0, 0, "t6_clear");
    for (int k = 0; k < 10; k++) rnd_step("t6_part", 0, 0);
    step(0, 0, 1, 1, 8, 8, 10, "t6_rst1");
    for (int k = 0; k < DEPTH; k++) rnd_step("t6_sweep", 0, 0);
    for (int k = 0; k < $urandom_range(10, 30); k++) rnd_step("t6_mix", 0, 0);
    step(0, 0, 1, 1, 11, 11, 12, "t6_rst2");
    for (int k = 0; k < DEPTH; k++) rnd_step("t6_sweep2", 0, 0);
    read_all("t6_read");

    // Random traffic with occasional clears and resets.
    for (int k = 0; k < 250; k++) rnd_step("rand", 60, 80);
    read_all("final_read");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
